tensor_core_sequencer: RTL and testbench
========================================

TENSOR_CORE_SEQUENCER -- requirements
Module: tensor_core_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; all state SHALL update on the rising edge of clk.
REQ-002 Port list (name, direction, width, meaning):
- clk  input  1  system clock
- reset  input  1  synchronous active-high reset
- in_valid  input  1  in_data carries a valid operand byte
- in_data  input  8  operand byte; matrix A first, then matrix B, each row-major
- in_ready  output  1  block accepts a byte this cycle
- tc_operand1  output  128  packed matrix A, driven to the tensor core's first input
- tc_operand2  output  128  packed matrix B, driven to the tensor core's second input
- tc_result  input  128  packed product returned combinationally by the tensor core
- out_valid  output  1  out_data carries a valid result byte
- out_data  output  8  result byte, row-major
- out_ready  input  1  downstream accepts out_data this cycle
- done  output  1  one-cycle pulse after the last result byte is accepted
REQ-003 Packing: element (i,j), i = row, j = column, each 0..3, SHALL occupy bits [((3-i)*4+(3-j))*8 +: 8]; element (0,0) SHALL occupy [127:120] and element (3,3) SHALL occupy [7:0].

Function
REQ-004 States SHALL be LOAD_A, LOAD_B, CAPTURE and SEND. A 4-bit index idx SHALL select the element, with row = idx[3:2] and column = idx[1:0].
REQ-005 A transfer SHALL occur on a rising edge where valid and ready are both 1. No transfer SHALL occur otherwise.
REQ-006 in_ready SHALL be 1 exactly in LOAD_A and LOAD_B. out_valid SHALL be 1 exactly in SEND.
REQ-007 LOAD_A: an input transfer SHALL write in_data to element idx of operand register A and increment idx. The transfer at idx=15 SHALL wrap idx to 0 and move the state to LOAD_B.
REQ-008 LOAD_B: the same rules SHALL apply using operand register B. The transfer at idx=15 SHALL wrap idx to 0 and move the state to CAPTURE.
REQ-009 tc_operand1 and tc_operand2 SHALL be driven directly from registers A and B. Both registers SHALL hold their values in every state until overwritten.
REQ-010 CAPTURE SHALL last exactly one cycle. At its closing edge, tc_result SHALL be latched into the result register and the state SHALL move to SEND.
REQ-011 Latency: the first out_valid cycle SHALL be the 2nd cycle after the edge that accepts the 32nd input byte.
REQ-012 SEND: out_data SHALL equal element idx of the result register.
- An output transfer SHALL increment idx.
- The transfer at idx=15 SHALL wrap idx to 0, move the state to LOAD_A and assert done for the next cycle only.
REQ-013 Backpressure: while out_valid=1 and out_ready=0, out_data and idx SHALL hold stable. out_valid SHALL never deassert before its transfer.
REQ-014 in_data SHALL be ignored outside LOAD_A and LOAD_B. out_ready SHALL be ignored outside SEND.
REQ-015 Arithmetic is the tensor core's modulo-256 8-bit result. The block SHALL pass result bytes through unmodified, without saturation or width extension.
REQ-016 After SEND, in_ready SHALL be 1 on the cycle after the final output transfer, so back-to-back operations need no idle cycle.

Reset
REQ-017 When reset is 1 at a rising edge, the following SHALL apply on the next cycle:
- state = LOAD_A, idx = 0
- registers A, B and result = 0, so tc_operand1 = tc_operand2 = 0 and out_data = 0
- in_ready = 1, out_valid = 0, done = 0
REQ-018 Reset SHALL take priority over any simultaneous transfer. A reset in any state, including mid-load or mid-SEND, SHALL discard partial data, and the next accepted byte SHALL be A(0,0).

Verification
REQ-019 The bench SHALL cover at least these directed scenarios:
- Identity: A = identity (0x01 on diagonal), B = bytes 0x00..0x0F, no stalls -> out_data = 0x00..0x0F; first out_valid 2 cycles after the 32nd accept; done pulses once.
- Wrap-around: A and B all 0x10 -> all 16 result bytes 0x00. A all 0x01, B all 0x03 -> all bytes 0x0C.
- Output backpressure: out_ready low for 5 cycles at idx=7 -> out_data holds result(1,3) and out_valid stays 1; the 16-byte sequence is unchanged.
- Input gaps: in_valid toggled 1/0 for each byte -> the same result as gap-free loading. tc_operand1 = 128'h0102...10 after A bytes 0x01..0x10.
- Mid-operation reset: reset after 20 input bytes -> in_ready = 1, tc_operand1 = 0; a fresh 32-byte load yields the correct product.
- Back-to-back: two operations streamed continuously -> in_ready rises on the cycle after the second done-causing transfer; the second result is correct.

Source files
------------

// File: rtl/tensor_core_sequencer.sv
// Streams two 4x4 byte matrices into operand registers and presents them to a
// combinational tensor core. The result is latched, then streamed out row-major.
module tensor_core_sequencer (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    input  logic [7:0]   in_data,
    output logic         in_ready,
    output logic [127:0] tc_operand1,
    output logic [127:0] tc_operand2,
    input  logic [127:0] tc_result,
    output logic         out_valid,
    output logic [7:0]   out_data,
    input  logic         out_ready,
    output logic         done
);

    typedef enum logic [1:0] {
        LOAD_A,
        LOAD_B,
        CAPTURE,
        SEND
    } state_t;

    state_t         state_reg, state_next;
    logic [3:0]     idx_reg, idx_next;
    logic           done_reg, done_next;
    logic [127:0]   a_reg, b_reg, r_reg;
    logic           in_xfer, out_xfer;
    logic [6:0]     byte_lsb;
    logic [7:0]     r_bytes [16];

    // Element idx lives at byte (15 - idx), i.e. (0,0) is the top byte.
    assign byte_lsb = {~idx_reg, 3'b000};

    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_result_bytes
            assign r_bytes[gi] = r_reg[(15 - gi) * 8 +: 8];
        end
    endgenerate

    assign tc_operand1 = a_reg;
    assign tc_operand2 = b_reg;
    assign out_data    = r_bytes[idx_reg];
    assign done        = done_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= LOAD_A;
            idx_reg   <= 4'd0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            done_reg  <= done_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        done_next  = 1'b0;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        in_xfer    = 1'b0;
        out_xfer   = 1'b0;
        case (state_reg)
            LOAD_A: begin
                in_ready = 1'b1;
                in_xfer  = in_valid;
                if (in_xfer) begin
                    idx_next = idx_reg + 4'd1;
                    if (idx_reg == 4'd15) state_next = LOAD_B;
                end
            end
            LOAD_B: begin
                in_ready = 1'b1;
                in_xfer  = in_valid;
                if (in_xfer) begin
                    idx_next = idx_reg + 4'd1;
                    if (idx_reg == 4'd15) state_next = CAPTURE;
                end
            end
            CAPTURE: begin
                state_next = SEND;
            end
            SEND: begin
                out_valid = 1'b1;
                out_xfer  = out_ready;
                if (out_xfer) begin
                    idx_next = idx_reg + 4'd1;
                    if (idx_reg == 4'd15) begin
                        state_next = LOAD_A;
                        done_next  = 1'b1;
                    end
                end
            end
            default: begin
                state_next = LOAD_A;
                idx_next   = 4'd0;
            end
        endcase
    end

    // Operand and result registers hold their contents until overwritten.
    always_ff @(posedge clk) begin
        if (reset) begin
            a_reg <= '0;
            b_reg <= '0;
            r_reg <= '0;
        end else begin
            if (in_xfer && state_reg == LOAD_A) a_reg[byte_lsb +: 8] <= in_data;
            if (in_xfer && state_reg == LOAD_B) b_reg[byte_lsb +: 8] <= in_data;
            if (state_reg == CAPTURE)           r_reg <= tc_result;
        end
    end

endmodule

// File: tb/tb_tensor_core_sequencer.sv
// Bench for tensor_core_sequencer: behavioural tensor core, table of operations,
// plus hand-written reset and back-to-back sequences.
module tb_tensor_core_sequencer;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic [7:0]   in_data;
    logic         in_ready;
    logic [127:0] tc_operand1;
    logic [127:0] tc_operand2;
    logic [127:0] tc_result;
    logic         out_valid;
    logic [7:0]   out_data;
    logic         out_ready;
    logic         done;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int ops_done = 0;

    tensor_core_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .tc_operand1 (tc_operand1),
        .tc_operand2 (tc_operand2),
        .tc_result   (tc_result),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready),
        .done        (done)
    );

    always #5 clk = ~clk;

    typedef logic [15:0][7:0] mat_t;  // mat_t[k] = element (k/4, k%4)

    function automatic mat_t ref_mm(input mat_t a, input mat_t b);
        mat_t c;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                int s = 0;
                for (int k = 0; k < 4; k++) s += int'(a[i*4+k]) * int'(b[k*4+j]);
                c[i*4+j] = 8'(s % 256);
            end
        return c;
    endfunction

    function automatic logic [127:0] pack(input mat_t m);
        logic [127:0] p = '0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                p[((3-i)*4 + (3-j))*8 +: 8] = m[i*4+j];
        return p;
    endfunction

    function automatic mat_t unpack(input logic [127:0] p);
        mat_t m;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                m[i*4+j] = p[((3-i)*4 + (3-j))*8 +: 8];
        return m;
    endfunction

    // Behavioural tensor core driven from the operand buses.
    always_comb tc_result = pack(ref_mm(unpack(tc_operand1), unpack(tc_operand2)));

    always @(posedge clk) if (done) done_cnt++;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // All tasks start and end positioned at a falling edge.
    task automatic load_bytes(input mat_t a, input mat_t b, input bit gaps, input int nbytes);
        for (int k = 0; k < nbytes; k++) begin
            in_valid  = 1'b1;
            in_data   = (k < 16) ? a[k] : b[k-16];
            out_ready = 1'($urandom);
            chk("in_ready_load", {127'd0, in_ready}, 128'd1);
            @(negedge clk);
            if (k == 15) chk("operand1_after_a", tc_operand1, pack(a));
            if (k == 31) chk("operand2_after_b", tc_operand2, pack(b));
            if (gaps && k != nbytes - 1) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                @(negedge clk);
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic capture_phase();
        chk("capture_no_valid", {127'd0, out_valid}, 128'd0);
        chk("capture_no_ready", {127'd0, in_ready}, 128'd0);
        in_valid  = 1'($urandom);
        in_data   = 8'($urandom);
        out_ready = 1'($urandom);
        @(negedge clk);
        chk("latency_first_valid", {127'd0, out_valid}, 128'd1);
    endtask

    task automatic recv(input mat_t exp, input int stall_idx, input int stall_len);
        for (int k = 0; k < 16; k++) begin
            if (k == stall_idx) begin
                out_ready = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    chk("stall_valid", {127'd0, out_valid}, 128'd1);
                    chk("stall_data", {120'd0, out_data}, {120'd0, exp[k]});
                    @(negedge clk);
                end
            end
            chk("out_valid", {127'd0, out_valid}, 128'd1);
            chk("out_byte", {120'd0, out_data}, {120'd0, exp[k]});
            out_ready = 1'b1;
            in_valid  = 1'($urandom);
            in_data   = 8'($urandom);
            @(negedge clk);
            out_ready = 1'b0;
        end
        in_valid = 1'b0;
        chk("done_pulse", {127'd0, done}, 128'd1);
        chk("in_ready_after_send", {127'd0, in_ready}, 128'd1);
    endtask

    task automatic pulse_reset();
        reset    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'($urandom);
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
        chk("rst_in_ready", {127'd0, in_ready}, 128'd1);
        chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
        chk("rst_done", {127'd0, done}, 128'd0);
        chk("rst_operand1", tc_operand1, 128'd0);
        chk("rst_operand2", tc_operand2, 128'd0);
        chk("rst_out_data", {120'd0, out_data}, 128'd0);
    endtask

    task automatic full_op(input mat_t a, input mat_t b, input bit gaps,
                           input int stall_idx, input int stall_len, input bit b2b);
        load_bytes(a, b, gaps, 32);
        capture_phase();
        recv(ref_mm(a, b), stall_idx, stall_len);
        ops_done++;
        if (!b2b) begin
            @(negedge clk);
            chk("done_low", {127'd0, done}, 128'd0);
        end
    endtask

    typedef struct {
        mat_t a;
        mat_t b;
        mat_t exp;
        bit   gaps;
        int   stall_idx;
        int   stall_len;
        bit   b2b;
    } vec_t;

    vec_t vecs[8];

    initial begin
        mat_t ident, ramp, ra, rb, got;
        reset = 1'b1; in_valid = 1'b0; in_data = 8'd0; out_ready = 1'b0;

        for (int k = 0; k < 16; k++) begin
            ident[k] = (k % 5 == 0) ? 8'h01 : 8'h00;
            ramp[k]  = 8'(k);
        end
        for (int v = 0; v < 8; v++) begin
            vecs[v].gaps = 1'b0; vecs[v].stall_idx = -1; vecs[v].stall_len = 0; vecs[v].b2b = 1'b0;
            for (int k = 0; k < 16; k++) begin
                vecs[v].a[k] = 8'($urandom);
                vecs[v].b[k] = 8'($urandom);
            end
        end
        vecs[0].a = ident; vecs[0].b = ramp; vecs[0].exp = ramp;
        for (int k = 0; k < 16; k++) begin
            vecs[1].a[k] = 8'h10; vecs[1].b[k] = 8'h10; vecs[1].exp[k] = 8'h00;
            vecs[2].a[k] = 8'h01; vecs[2].b[k] = 8'h03; vecs[2].exp[k] = 8'h0C;
            vecs[4].a[k] = 8'(k + 1);
        end
        vecs[3].a = ident; vecs[3].b = ramp; vecs[3].exp = ramp;
        vecs[3].stall_idx = 7; vecs[3].stall_len = 5;
        vecs[4].gaps = 1'b1;
        vecs[5].b2b = 1'b1;
        vecs[6].b2b = 1'b1; vecs[6].gaps = 1'b1;
        vecs[6].stall_idx = int'($urandom_range(0, 15)); vecs[6].stall_len = int'($urandom_range(1, 4));
        vecs[7].stall_idx = int'($urandom_range(0, 15)); vecs[7].stall_len = 2;
        for (int v = 4; v < 8; v++) vecs[v].exp = ref_mm(vecs[v].a, vecs[v].b);

        @(negedge clk);
        pulse_reset();

        for (int v = 0; v < 8; v++) begin
            load_bytes(vecs[v].a, vecs[v].b, vecs[v].gaps, 32);
            if (v == 4) chk("operand1_ramp", tc_operand1, 128'h0102030405060708090a0b0c0d0e0f10);
            capture_phase();
            recv(vecs[v].exp, vecs[v].stall_idx, vecs[v].stall_len);
            ops_done++;
            $display("op %0d: gaps=%0d stall_idx=%0d b2b=%0d checks=%0d errors=%0d",
                     v, vecs[v].gaps, vecs[v].stall_idx, vecs[v].b2b, checks, errors);
            if (!vecs[v].b2b) begin
                @(negedge clk);
                chk("done_low", {127'd0, done}, 128'd0);
            end
        end

        // Reset after 20 input bytes discards the partial load.
        for (int k = 0; k < 16; k++) begin
            ra[k] = 8'($urandom); rb[k] = 8'($urandom);
        end
        load_bytes(ra, rb, 1'b0, 20);
        pulse_reset();
        full_op(rb, ra, 1'b0, -1, 0, 1'b0);
        $display("op mid_load_reset: checks=%0d errors=%0d", checks, errors);

        // Reset in the middle of SEND, then a fresh operation restarts at element (0,0).
        load_bytes(ra, rb, 1'b0, 32);
        capture_phase();
        got = ref_mm(ra, rb);
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("mid_send_byte3", {120'd0, out_data}, {120'd0, got[3]});
        out_ready = 1'b0;
        pulse_reset();
        full_op(ra, rb, 1'b1, 0, 3, 1'b0);
        $display("op mid_send_reset: checks=%0d errors=%0d", checks, errors);

        chk("done_pulse_count", 128'(done_cnt), 128'(ops_done));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
